// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one ready-handshaked memory port between instruction
// fetch (IF, read-only) and load/store (LS). Runs one transaction at a time,
// returns read data with a one-cycle done pulse, and aborts a transaction
// with err_o when the memory does not answer within TIMEOUT busy cycles.
// Optional build macro MEM_ARBITER_RR_EN: round-robin arbitration between
// IF and LS; without it, LS has fixed priority and no pointer is built.
module mem_arbiter #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic                clk_100MHz,
   input  logic                arst_n,
   input  logic                if_req_i,
   input  logic [ADDR_W-1:0]   if_addr_i,
   output logic                if_done_o,
   output logic [DATA_W-1:0]   if_rdata_o,
   input  logic                ls_req_i,
   input  logic                ls_we_i,
   input  logic [ADDR_W-1:0]   ls_addr_i,
   input  logic [DATA_W-1:0]   ls_wdata_i,
   input  logic [DATA_W/8-1:0] ls_wstrb_i,
   output logic                ls_done_o,
   output logic [DATA_W-1:0]   ls_rdata_o,
   output logic                err_o,
   output logic                hold_o,
   output logic                mem_req_o,
   output logic                mem_we_o,
   output logic [ADDR_W-1:0]   mem_addr_o,
   output logic [DATA_W-1:0]   mem_wdata_o,
   output logic [DATA_W/8-1:0] mem_wstrb_o,
   input  logic [DATA_W-1:0]   mem_rdata_i,
   input  logic                mem_ready_i
);

   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned CNT_W  = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_LS = 2'd2
   } state_e;

   state_e             state_q;
   logic [CNT_W-1:0]   tmo_cnt_q;
   logic               if_done_q;
   logic               ls_done_q;
   logic               err_q;
   logic [DATA_W-1:0]  if_rdata_q;
   logic [DATA_W-1:0]  ls_rdata_q;
   logic               mem_req_q;
   logic               mem_we_q;
   logic [ADDR_W-1:0]  mem_addr_q;
   logic [DATA_W-1:0]  mem_wdata_q;
   logic [STRB_W-1:0]  mem_wstrb_q;

   logic               busy_if;
   logic               busy_ls;
   logic               tmo_hit;
   logic               complete_d;
   logic               arb_en_d;
   logic               if_elig;
   logic               ls_elig;
   logic               grant_if_d;
   logic               grant_ls_d;

`ifdef MEM_ARBITER_RR_EN
   // 1 = LS was granted last, 0 = IF was granted last
   logic               rr_last_ls_q;
`endif

   // Completion/timeout detection, eligibility and winner selection
   always_comb begin
      busy_if    = (state_q == BUSY_IF);
      busy_ls    = (state_q == BUSY_LS);
      tmo_hit    = (busy_if | busy_ls) & (tmo_cnt_q == CNT_LAST);
      complete_d = (busy_if | busy_ls) & (mem_ready_i | tmo_hit);
      arb_en_d   = (state_q == IDLE) | complete_d;
      // A requester whose done pulse is showing still has its old request
      // up, so it only becomes eligible again one edge later.
      if_elig    = if_req_i & ~if_done_q & ~busy_if;
      ls_elig    = ls_req_i & ~ls_done_q & ~busy_ls;
`ifdef MEM_ARBITER_RR_EN
      grant_ls_d = ls_elig & (~if_elig | ~rr_last_ls_q);
`else
      grant_ls_d = ls_elig;
`endif
      grant_if_d = if_elig & ~grant_ls_d;
   end

`ifdef MEM_ARBITER_RR_EN
   // Round-robin pointer remembers who was granted most recently
   always_ff @(posedge clk_100MHz or negedge arst_n) begin
      if (!arst_n) begin
         rr_last_ls_q <= 1'b0;
      end else if (arb_en_d && (grant_if_d || grant_ls_d)) begin
         rr_last_ls_q <= grant_ls_d;
      end
   end
`endif

   // Transaction FSM with registered memory-bus and requester outputs
   always_ff @(posedge clk_100MHz or negedge arst_n) begin
      if (!arst_n) begin
         state_q     <= IDLE;
         tmo_cnt_q   <= '0;
         if_done_q   <= 1'b0;
         ls_done_q   <= 1'b0;
         err_q       <= 1'b0;
         if_rdata_q  <= '0;
         ls_rdata_q  <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wstrb_q <= '0;
      end else begin
         if_done_q <= 1'b0;
         ls_done_q <= 1'b0;
         err_q     <= 1'b0;

         case (state_q)
            BUSY_IF: begin
               if (complete_d) begin
                  if_done_q <= 1'b1;
                  err_q     <= ~mem_ready_i;
                  if (mem_ready_i) begin
                     if_rdata_q <= mem_rdata_i;
                  end
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
               end
            end
            BUSY_LS: begin
               if (complete_d) begin
                  ls_done_q <= 1'b1;
                  err_q     <= ~mem_ready_i;
                  if (mem_ready_i && !mem_we_q) begin
                     ls_rdata_q <= mem_rdata_i;
                  end
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
               end
            end
            default: ;
         endcase

         // Arbitration in IDLE and on every completion edge (back-to-back)
         if (arb_en_d) begin
            tmo_cnt_q <= '0;
            if (grant_ls_d) begin
               state_q     <= BUSY_LS;
               mem_req_q   <= 1'b1;
               mem_we_q    <= ls_we_i;
               mem_addr_q  <= ls_addr_i;
               mem_wdata_q <= ls_wdata_i;
               mem_wstrb_q <= ls_we_i ? ls_wstrb_i : '0;
            end else if (grant_if_d) begin
               state_q     <= BUSY_IF;
               mem_req_q   <= 1'b1;
               mem_we_q    <= 1'b0;
               mem_addr_q  <= if_addr_i;
               mem_wdata_q <= '0;
               mem_wstrb_q <= '0;
            end else begin
               state_q     <= IDLE;
               mem_req_q   <= 1'b0;
               mem_we_q    <= 1'b0;
               mem_wstrb_q <= '0;
            end
         end
      end
   end

   assign if_done_o   = if_done_q;
   assign ls_done_o   = ls_done_q;
   assign err_o       = err_q;
   assign if_rdata_o  = if_rdata_q;
   assign ls_rdata_o  = ls_rdata_q;
   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign mem_wstrb_o = mem_wstrb_q;
   assign hold_o      = (if_req_i & ~if_done_q) | (ls_req_i & ~ls_done_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (default build: fixed LS priority, TIMEOUT=16).
module tb_mem_arbiter;

   logic        clk;
   logic        arst_n;
   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic        if_done_o;
   logic [31:0] if_rdata_o;
   logic        ls_req_i;
   logic        ls_we_i;
   logic [31:0] ls_addr_i;
   logic [31:0] ls_wdata_i;
   logic [3:0]  ls_wstrb_i;
   logic        ls_done_o;
   logic [31:0] ls_rdata_o;
   logic        err_o;
   logic        hold_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [3:0]  mem_wstrb_o;
   logic [31:0] mem_rdata_i;
   logic        mem_ready_i;

   int checks = 0;
   int errors = 0;

   mem_arbiter #(
      .ADDR_W (32),
      .DATA_W (32),
      .TIMEOUT(16)
   ) dut (
      .clk_100MHz (clk),
      .arst_n     (arst_n),
      .if_req_i   (if_req_i),
      .if_addr_i  (if_addr_i),
      .if_done_o  (if_done_o),
      .if_rdata_o (if_rdata_o),
      .ls_req_i   (ls_req_i),
      .ls_we_i    (ls_we_i),
      .ls_addr_i  (ls_addr_i),
      .ls_wdata_i (ls_wdata_i),
      .ls_wstrb_i (ls_wstrb_i),
      .ls_done_o  (ls_done_o),
      .ls_rdata_o (ls_rdata_o),
      .err_o      (err_o),
      .hold_o     (hold_o),
      .mem_req_o  (mem_req_o),
      .mem_we_o   (mem_we_o),
      .mem_addr_o (mem_addr_o),
      .mem_wdata_o(mem_wdata_o),
      .mem_wstrb_o(mem_wstrb_o),
      .mem_rdata_i(mem_rdata_i),
      .mem_ready_i(mem_ready_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        is_ls;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] rdata;       // value driven on mem_rdata_i
      int unsigned delay;       // busy cycle index at which ready is given (99 = never)
      int unsigned exp_cycles;  // busy cycle index of the completion edge
      logic [31:0] exp_rdata;   // requester rdata after completion
      logic        exp_err;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input int idx,
                        input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int unsigned k;
      bit seen;
      if_req_i    = !v.is_ls;
      ls_req_i    = v.is_ls;
      ls_we_i     = v.we;
      if_addr_i   = v.addr;
      ls_addr_i   = v.addr;
      ls_wdata_i  = v.wdata;
      ls_wstrb_i  = v.wstrb;
      mem_ready_i = 1'b0;
      #1;
      check("hold_on_req", idx, 32'(hold_o), 32'd1);
      check("req_before_grant", idx, 32'(mem_req_o), 32'd0);
      @(posedge clk); #1;
      check("grant_req", idx, 32'(mem_req_o), 32'd1);
      check("grant_we", idx, 32'(mem_we_o), 32'(v.we));
      check("grant_addr", idx, mem_addr_o, v.addr);
      check("grant_wstrb", idx, 32'(mem_wstrb_o), v.we ? 32'(v.wstrb) : 32'd0);
      if (v.we) check("grant_wdata", idx, mem_wdata_o, v.wdata);
      seen = 1'b0;
      k = 0;
      while (!seen && k < 40) begin
         mem_ready_i = (k == v.delay);
         mem_rdata_i = v.rdata;
         @(posedge clk); #1;
         if ((v.is_ls ? ls_done_o : if_done_o) === 1'b1) begin
            seen = 1'b1;
         end else begin
            check("busy_req", idx, 32'(mem_req_o), 32'd1);
            check("busy_addr", idx, mem_addr_o, v.addr);
            k++;
         end
      end
      mem_ready_i = 1'b0;
      check("done_cycle", idx, k, v.exp_cycles);
      check("other_done", idx, 32'(v.is_ls ? if_done_o : ls_done_o), 32'd0);
      check("rdata", idx, v.is_ls ? ls_rdata_o : if_rdata_o, v.exp_rdata);
      check("err_with_done", idx, 32'(err_o), 32'(v.exp_err));
      check("hold_at_done", idx, 32'(hold_o), 32'd0);
      check("idle_after_done", idx, 32'(mem_req_o), 32'd0);
      check("we_after_done", idx, 32'(mem_we_o), 32'd0);
      if_req_i = 1'b0;
      ls_req_i = 1'b0;
      @(posedge clk); #1;
      check("done_one_cycle", idx, 32'(v.is_ls ? ls_done_o : if_done_o), 32'd0);
      check("err_one_cycle", idx, 32'(err_o), 32'd0);
      check("still_idle", idx, 32'(mem_req_o), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      //           ls    we    addr          wdata         wstrb  rdata         dly cyc exp_rdata     err
      vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,        4'h0, 32'h0000_0013, 1,  1, 32'h0000_0013, 1'b0};
      vecs[1] = '{1'b1, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 4'h3, 32'h5555_5555, 0,  0, 32'h0000_0000, 1'b0};
      vecs[2] = '{1'b1, 1'b0, 32'h0000_3000, 32'h0,        4'hF, 32'hCAFE_F00D, 2,  2, 32'hCAFE_F00D, 1'b0};
      vecs[3] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0,        4'h0, 32'h0000_0BAD, 99, 15, 32'h0000_0013, 1'b1};
      vecs[4] = '{1'b1, 1'b0, 32'h0000_3004, 32'h0,        4'h0, 32'h1234_5678, 15, 15, 32'h1234_5678, 1'b0};
      vecs[5] = '{1'b1, 1'b1, 32'h0000_0010, 32'h0BAD_C0DE, 4'hF, 32'h9999_9999, 99, 15, 32'h1234_5678, 1'b1};
      vecs[6] = '{1'b1, 1'b0, 32'h0000_3008, 32'h0,        4'h0, 32'hA5A5_A5A5, 3,  3, 32'hA5A5_A5A5, 1'b0};

      arst_n      = 1'b0;
      if_req_i    = 1'b0;
      if_addr_i   = '0;
      ls_req_i    = 1'b0;
      ls_we_i     = 1'b0;
      ls_addr_i   = '0;
      ls_wdata_i  = '0;
      ls_wstrb_i  = '0;
      mem_rdata_i = '0;
      mem_ready_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_if_done", 0, 32'(if_done_o), 32'd0);
      check("rst_if_rdata", 0, if_rdata_o, 32'd0);
      check("rst_ls_done", 0, 32'(ls_done_o), 32'd0);
      check("rst_ls_rdata", 0, ls_rdata_o, 32'd0);
      check("rst_err", 0, 32'(err_o), 32'd0);
      check("rst_hold", 0, 32'(hold_o), 32'd0);
      check("rst_mem_req", 0, 32'(mem_req_o), 32'd0);
      check("rst_mem_we", 0, 32'(mem_we_o), 32'd0);
      check("rst_mem_addr", 0, mem_addr_o, 32'd0);
      check("rst_mem_wdata", 0, mem_wdata_o, 32'd0);
      check("rst_mem_wstrb", 0, 32'(mem_wstrb_o), 32'd0);
      arst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 7; i++) begin
         run_vec(i, vecs[i]);
      end

      // Simultaneous requests, ready always high: LS first, IF back-to-back
      if_addr_i   = 32'h0000_0200;
      ls_addr_i   = 32'h0000_4000;
      ls_we_i     = 1'b0;
      ls_wstrb_i  = 4'h0;
      mem_ready_i = 1'b1;
      mem_rdata_i = 32'h1111_1111;
      if_req_i    = 1'b1;
      ls_req_i    = 1'b1;
      @(posedge clk); #1;
      check("both_first_req", 100, 32'(mem_req_o), 32'd1);
      check("both_first_ls", 100, mem_addr_o, 32'h0000_4000);
      @(posedge clk); #1;
      check("both_ls_done", 100, 32'(ls_done_o), 32'd1);
      check("both_ls_rdata", 100, ls_rdata_o, 32'h1111_1111);
      check("both_b2b_req", 100, 32'(mem_req_o), 32'd1);
      check("both_b2b_if", 100, mem_addr_o, 32'h0000_0200);
      check("both_hold", 100, 32'(hold_o), 32'd1);
      mem_rdata_i = 32'h2222_2222;
      @(posedge clk); #1;
      check("both_if_done", 100, 32'(if_done_o), 32'd1);
      check("both_ls_done_gone", 100, 32'(ls_done_o), 32'd0);
      check("both_if_rdata", 100, if_rdata_o, 32'h2222_2222);
      check("both_no_regrant", 100, 32'(mem_req_o), 32'd0);
      if_req_i    = 1'b0;
      ls_req_i    = 1'b0;
      mem_ready_i = 1'b0;
      @(posedge clk); #1;
      check("both_idle", 100, 32'(mem_req_o), 32'd0);
      check("both_if_done_gone", 100, 32'(if_done_o), 32'd0);

      // Asynchronous reset while BUSY_LS drops the transaction
      ls_addr_i = 32'h0000_5000;
      ls_we_i   = 1'b0;
      ls_req_i  = 1'b1;
      @(posedge clk); #1;
      check("rstb_busy", 200, 32'(mem_req_o), 32'd1);
      @(posedge clk); #1;
      arst_n = 1'b0;
      #1;
      check("rstb_req0", 200, 32'(mem_req_o), 32'd0);
      check("rstb_addr0", 200, mem_addr_o, 32'd0);
      check("rstb_done0", 200, 32'(ls_done_o), 32'd0);
      check("rstb_err0", 200, 32'(err_o), 32'd0);
      check("rstb_rdata0", 200, ls_rdata_o, 32'd0);
      @(posedge clk); #1;
      check("rstb_held_done0", 200, 32'(ls_done_o), 32'd0);
      arst_n = 1'b1;
      @(posedge clk); #1;
      check("rstb_regrant", 200, 32'(mem_req_o), 32'd1);
      check("rstb_regrant_addr", 200, mem_addr_o, 32'h0000_5000);
      mem_ready_i = 1'b1;
      mem_rdata_i = 32'h0000_0077;
      @(posedge clk); #1;
      check("rstb_done", 200, 32'(ls_done_o), 32'd1);
      check("rstb_rdata", 200, ls_rdata_o, 32'h0000_0077);
      check("rstb_err", 200, 32'(err_o), 32'd0);
      ls_req_i    = 1'b0;
      mem_ready_i = 1'b0;
      @(posedge clk); #1;
      check("rstb_final_idle", 200, 32'(mem_req_o), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
